// File: rtl/gpr_writeback_queue.sv
// gpr_writeback_queue: collects ALU and load writebacks into a small in-order
// FIFO and drains it through the register file's single write port, one entry
// per clock. Publishes a pending-write bitmap for issue-stage interlocks.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, adds fwd_addr/fwd_hit/fwd_data so a reader can take the
//   youngest queued value for a register instead of stalling on pending.
//
// Handshake: a source's result transfers on a clk edge where its valid and
// ready are both high; the source holds valid/dest/data stable until then.
// Ready depends only on current occupancy (not on the same-cycle pop), and the
// ALU source only gets the last free slot when the load source is idle. When
// both transfer together the load entry is the older of the two.
module gpr_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_wb_valid,
  input  logic [2:0]       mem_wb_dest,
  input  logic [15:0]      mem_wb_data,
  output logic             mem_wb_ready,
  input  logic             alu_wb_valid,
  input  logic [2:0]       alu_wb_dest,
  input  logic [15:0]      alu_wb_data,
  output logic             alu_wb_ready,
  output logic             reg_write_en,
  output logic [2:0]       reg_write_dest,
  output logic [15:0]      reg_write_data,
  output logic [7:0]       pending,
  output logic [CNT_W-1:0] count,
  output logic             full,
`ifdef WB_BYPASS_EN
  input  logic [2:0]       fwd_addr,
  output logic             fwd_hit,
  output logic [15:0]      fwd_data,
`endif
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]       dest_q [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] free;
  logic [PTR_W-1:0] alu_slot;
  logic             mem_push;
  logic             alu_push;
  logic             pop;

  // Occupancy view; free slots deliberately ignore this cycle's pop.
  assign free  = CNT_W'(DEPTH) - count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  assign mem_wb_ready = (free != '0);
  assign alu_wb_ready = (free >= CNT_W'(2)) || ((free != '0) && !mem_wb_valid);

  assign mem_push = mem_wb_valid && mem_wb_ready;
  assign alu_push = alu_wb_valid && alu_wb_ready;
  // The register file never back-pressures, so the head leaves every cycle.
  assign pop      = !empty;

  // The ALU entry lands behind the load entry when both transfer together.
  assign alu_slot = wr_ptr + PTR_W'(mem_push);

  // Head of the queue drives the write port; zeros when nothing is queued.
  assign reg_write_en   = !empty;
  assign reg_write_dest = empty ? 3'd0  : dest_q[rd_ptr];
  assign reg_write_data = empty ? 16'd0 : data_q[rd_ptr];

  // Control state: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (mem_push) valid_q[wr_ptr]   <= 1'b1;
      if (alu_push) valid_q[alu_slot] <= 1'b1;
      wr_ptr  <= wr_ptr + PTR_W'(mem_push) + PTR_W'(alu_push);
      count_q <= count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  // Entry payload storage; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && mem_push) begin
      dest_q[wr_ptr] <= mem_wb_dest;
      data_q[wr_ptr] <= mem_wb_data;
    end
    if (!rst && alu_push) begin
      dest_q[alu_slot] <= alu_wb_dest;
      data_q[alu_slot] <= alu_wb_data;
    end
  end

  // Pending bitmap: one bit per register with at least one queued write.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending[dest_q[i]] = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk from oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (valid_q[fwd_idx] && (dest_q[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
`endif

endmodule
